fpu_ss_result_fifo: RTL and testbench



---
 rtl/fpu_ss_result_fifo.sv | 106 ++++++++++
 tb/tb_fpu_ss_result_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_result_fifo.sv
// Elastic in-order result buffer between the FPU subsystem and the core result port.
// Latency 1 cycle, no bypass; in_ready_o drops when full regardless of out_ready_i, and out_* hold while stalled.
module fpu_ss_result_fifo #(
  parameter int DEPTH      = 4,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [ID_WIDTH-1:0]   in_id_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [4:0]            in_rd_i,
  input  logic                  in_we_i,
  input  logic                  in_exc_i,
  input  logic [5:0]            in_exccode_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ID_WIDTH-1:0]   out_id_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [4:0]            out_rd_o,
  output logic                  out_we_o,
  output logic                  out_exc_o,
  output logic [5:0]            out_exccode_o,
  output logic [CNT_WIDTH-1:0]  count_o
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
  } entry_t;

  entry_t                 mem [DEPTH];
  entry_t                 in_entry;
  entry_t                 head;
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [CNT_WIDTH-1:0]   count;
  logic                   push;
  logic                   pop;

  assign in_entry = '{id: in_id_i, data: in_data_i, rd: in_rd_i, we: in_we_i,
                      exc: in_exc_i, exccode: in_exccode_i};

  // Both flags come from the registered count only, so no input reaches an output combinationally.
  assign in_ready_o  = (count != FULL_CNT);
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign count_o     = count;

  assign head          = mem[rd_ptr];
  assign out_id_o      = head.id;
  assign out_data_o    = head.data;
  assign out_rd_o      = head.rd;
  assign out_we_o      = head.we;
  assign out_exc_o     = head.exc;
  assign out_exccode_o = head.exccode;

  // Storage is cleared on reset so the head payload reads as zero out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    (count == FULL_CNT) |-> !push);
  a_in_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (in_valid_i && !in_ready_o) |=> (in_valid_i && $stable(in_entry)));
  a_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
    count <= FULL_CNT);

endmodule

// File: tb/tb_fpu_ss_result_fifo.sv
// Directed bench for fpu_ss_result_fifo: inputs change 1ns after the rising edge, outputs checked there too.
module tb_fpu_ss_result_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  in_id_i;
  logic [31:0] in_data_i;
  logic [4:0]  in_rd_i;
  logic        in_we_i;
  logic        in_exc_i;
  logic [5:0]  in_exccode_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  out_id_o;
  logic [31:0] out_data_o;
  logic [4:0]  out_rd_o;
  logic        out_we_o;
  logic        out_exc_o;
  logic [5:0]  out_exccode_o;
  logic [2:0]  count_o;

  int checks   = 0;
  int failures = 0;
  int exp_id;

  fpu_ss_result_fifo #(.DEPTH(4), .ID_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_id_i(in_id_i), .in_data_i(in_data_i), .in_rd_i(in_rd_i),
    .in_we_i(in_we_i), .in_exc_i(in_exc_i), .in_exccode_i(in_exccode_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_id_o(out_id_o), .out_data_o(out_data_o), .out_rd_o(out_rd_o),
    .out_we_o(out_we_o), .out_exc_o(out_exc_o), .out_exccode_o(out_exccode_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [3:0] id, input logic [31:0] data);
    in_valid_i   = vld;
    in_id_i      = id;
    in_data_i    = data;
    in_rd_i      = 5'(id + 4'd1);
    in_we_i      = id[0];
    in_exc_i     = id[1];
    in_exccode_i = {2'b00, id};
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
    drive(1'b0, 4'd0, 32'd0);
    #3;
    check("rst_valid", out_valid_o, 0);
    check("rst_ready", in_ready_o, 1);
    check("rst_count", count_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_id", out_id_o, 0);
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Single result, core ready.
    out_ready_i = 1'b1;
    drive(1'b1, 4'd3, 32'h3F80_0000);
    in_rd_i = 5'd5; in_we_i = 1'b1; in_exc_i = 1'b0; in_exccode_i = 6'd0;
    tick();
    drive(1'b0, 4'd0, 32'd0);
    check("t1_valid", out_valid_o, 1);
    check("t1_count", count_o, 1);
    check("t1_id", out_id_o, 3);
    check("t1_data", out_data_o, 32'h3F80_0000);
    check("t1_rd", out_rd_o, 5);
    check("t1_we", out_we_o, 1);
    check("t1_exc", out_exc_o, 0);
    tick();
    check("t1_count_pop", count_o, 0);
    check("t1_valid_pop", out_valid_o, 0);

    // Fill with the core stalled, then drain in order.
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i), 32'h1111_1111 * i);
      tick();
    end
    drive(1'b0, 4'd0, 32'd0);
    check("t2_count_full", count_o, 4);
    check("t2_ready_full", in_ready_o, 0);
    check("t2_head0", out_id_o, 0);
    check("t2_exccode0", out_exccode_o, 0);
    out_ready_i = 1'b1;
    tick();
    check("t2_ready_after_pop", in_ready_o, 1);
    check("t2_count3", count_o, 3);
    check("t2_head1", out_id_o, 1);
    check("t2_data1", out_data_o, 32'h1111_1111);
    tick();
    check("t2_head2", out_id_o, 2);
    check("t2_exc2", out_exc_o, 1);
    tick();
    check("t2_head3", out_id_o, 3);
    check("t2_rd3", out_rd_o, 4);
    tick();
    check("t2_empty_valid", out_valid_o, 0);
    check("t2_empty_count", count_o, 0);

    // Full with push and pop offered together: pop only, then both.
    out_ready_i = 1'b0;
    for (int i = 4; i < 8; i++) begin
      drive(1'b1, 4'(i), 32'hA000_0000 + 32'(i));
      tick();
    end
    check("t3_full_count", count_o, 4);
    out_ready_i = 1'b1;
    drive(1'b1, 4'd8, 32'hA000_0008);
    tick();
    check("t3_pop_no_push", count_o, 3);
    check("t3_ready_back", in_ready_o, 1);
    check("t3_head5", out_id_o, 5);
    tick();
    drive(1'b0, 4'd0, 32'd0);
    check("t3_push_pop_count", count_o, 3);
    check("t3_head6", out_id_o, 6);
    tick();
    check("t3_head7", out_id_o, 7);
    tick();
    check("t3_head8", out_id_o, 8);
    check("t3_data8", out_data_o, 32'hA000_0008);
    tick();
    check("t3_drained", count_o, 0);

    // Streaming ten results across pointer wrap.
    exp_id = 0;
    for (int k = 0; k < 12; k++) begin
      if (k < 10) drive(1'b1, 4'(k), 32'h0101_0101 * k);
      else        drive(1'b0, 4'd0, 32'd0);
      tick();
      if (out_valid_o) begin
        check("t4_stream_id", out_id_o, 64'(exp_id));
        check("t4_stream_data", out_data_o, 64'(32'h0101_0101 * exp_id));
        exp_id++;
      end
    end
    check("t4_stream_total", 64'(exp_id), 10);
    check("t4_stream_count", count_o, 0);

    // Flush with two held entries while push and pop are both active.
    out_ready_i = 1'b0;
    drive(1'b1, 4'hA, 32'h0000_000A); tick();
    drive(1'b1, 4'hB, 32'h0000_000B); tick();
    drive(1'b0, 4'd0, 32'd0);
    check("t5_count2", count_o, 2);
    flush_i = 1'b1; out_ready_i = 1'b1;
    drive(1'b1, 4'hC, 32'h0000_000C);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 4'd0, 32'd0);
    check("t5_flush_count", count_o, 0);
    check("t5_flush_valid", out_valid_o, 0);
    tick();
    check("t5_dropped_valid", out_valid_o, 0);
    drive(1'b1, 4'hD, 32'h0000_000D);
    tick();
    drive(1'b0, 4'd0, 32'd0);
    check("t5_after_flush_id", out_id_o, 4'hD);
    tick();
    check("t5_after_flush_count", count_o, 0);

    // Asynchronous reset with three entries held.
    out_ready_i = 1'b0;
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 4'(i), 32'(i));
      tick();
    end
    drive(1'b0, 4'd0, 32'd0);
    check("t6_count3", count_o, 3);
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_async_valid", out_valid_o, 0);
    check("t6_async_ready", in_ready_o, 1);
    check("t6_async_count", count_o, 0);
    check("t6_async_data", out_data_o, 0);
    tick();
    rst_i = 1'b0;
    tick();
    check("t6_post_count", count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
